// File: rtl/fp_norm_round_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_round_pipe_if
// Purpose  : Handshake and data bundle for the FP normalise/round stage.
//            master = producer/consumer side, slave = the pipeline stage.
// Signals  : in_valid/in_ready, sign_in, exp_in, frac_in, carry_out, frm,
//            inv_in, dz_in, ovf_in, unf_in (upstream beat);
//            out_valid/out_ready, fp_out, flags (downstream result).
// Revision : 1.0 - initial release
// ============================================================================
interface fp_norm_round_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      sign_in;
    logic [EXP_W-1:0]          exp_in;
    logic [FRAC_W+2:0]         frac_in;
    logic                      carry_out;
    logic [2:0]                frm;
    logic                      inv_in;
    logic                      dz_in;
    logic                      ovf_in;
    logic                      unf_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+FRAC_W:0]     fp_out;
    logic [4:0]                flags;

    modport master (
        output in_valid, sign_in, exp_in, frac_in, carry_out, frm,
               inv_in, dz_in, ovf_in, unf_in, out_ready,
        input  in_ready, out_valid, fp_out, flags
    );

    modport slave (
        input  in_valid, sign_in, exp_in, frac_in, carry_out, frm,
               inv_in, dz_in, ovf_in, unf_in, out_ready,
        output in_ready, out_valid, fp_out, flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_norm_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_round_pipe
// Purpose  : Two-stage valid/ready pipeline closing the FP adder datapath.
//            Stage 1 normalises the raw sum (carry shift or leading-zero
//            shift), stage 2 rounds per frm, resolves exceptions and
//            registers the IEEE-754 result with RISC-V fflags {NV,DZ,OF,UF,NX}.
// Ports    : clk, rst (sync, active-high)
//            bus : fp_norm_round_pipe_if.slave (input beat, result, handshake)
// Options  : FP_OVF_SAT_EN - overflow result follows rounding direction
//            (max-finite for RTZ / RDN-positive / RUP-negative) instead of
//            always returning infinity.
// Revision : 1.0 - initial release
// ============================================================================
module fp_norm_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_norm_round_pipe_if.slave  bus
);
    localparam int               c_SIG_W       = FRAC_W + 3;
    localparam int               c_LZC_W       = $clog2(c_SIG_W + 1);
    localparam logic [EXP_W-1:0] c_EXP_ONES    = '1;
    localparam logic [EXP_W-1:0] c_EXP_MAX_FIN = c_EXP_ONES - EXP_W'(1);

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_load    = ~r_s2_valid | bus.out_ready;
    assign w_s1_load    = ~r_s1_valid | w_s2_load;
    assign bus.in_ready = w_s1_load;

    // ---------------- stage 1: normalise ----------------
    logic [c_LZC_W-1:0] w_lzc;
    logic [EXP_W:0]     w_lzc_ext;
    logic [EXP_W:0]     w_exp_ext;
    logic [EXP_W:0]     w_norm_exp;
    logic [c_SIG_W-2:0] w_norm_frac;   // {fraction, G, S}; hidden bit implied
    logic               w_zero;
    logic               w_norm_ovf;
    logic               w_norm_unf;

    // Lowest set bit is visited last from the MSB's perspective, so scanning
    // upward leaves the count of the most significant one.
    always_comb begin
        w_lzc = c_LZC_W'(c_SIG_W);
        for (int i = 0; i < c_SIG_W; i++) begin
            if (bus.frac_in[i]) w_lzc = c_LZC_W'(c_SIG_W - 1 - i);
        end
    end

    assign w_lzc_ext = (EXP_W+1)'(w_lzc);
    assign w_exp_ext = {1'b0, bus.exp_in};

    always_comb begin
        w_zero     = ~bus.carry_out & (bus.frac_in == '0);
        w_norm_ovf = 1'b0;
        w_norm_unf = 1'b0;
        if (bus.carry_out) begin
            // carry becomes the hidden bit; both dropped bits fold into S
            w_norm_frac = {bus.frac_in[c_SIG_W-1:2], |bus.frac_in[1:0]};
            w_norm_exp  = w_exp_ext + (EXP_W+1)'(1);
            w_norm_ovf  = (bus.exp_in == c_EXP_MAX_FIN);
        end else begin
            w_norm_frac = (c_SIG_W-1)'(bus.frac_in << w_lzc);
            w_norm_exp  = w_exp_ext - w_lzc_ext;
            w_norm_unf  = ~w_zero & (w_exp_ext <= w_lzc_ext);
        end
    end

    logic               r_s1_sign;
    logic [EXP_W:0]     r_s1_exp;
    logic [c_SIG_W-2:0] r_s1_frac;
    logic [2:0]         r_s1_frm;
    logic               r_s1_inv;
    logic               r_s1_dz;
    logic               r_s1_ovf;
    logic               r_s1_unf;
    logic               r_s1_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_frm   <= '0;
            r_s1_inv   <= 1'b0;
            r_s1_dz    <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_unf   <= 1'b0;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign <= bus.sign_in;
                r_s1_exp  <= w_norm_exp;
                r_s1_frac <= w_norm_frac;
                r_s1_frm  <= bus.frm;
                r_s1_inv  <= bus.inv_in;
                r_s1_dz   <= bus.dz_in;
                r_s1_ovf  <= bus.ovf_in | w_norm_ovf;
                r_s1_unf  <= bus.unf_in | w_norm_unf;
                r_s1_zero <= w_zero;
            end
        end
    end

    // ---------------- stage 2: round / select ----------------
    logic                  w_lsb;
    logic                  w_g;
    logic                  w_s;
    logic                  w_inc;
    logic                  w_rnd_carry;
    logic [FRAC_W-1:0]     w_rnd_frac;
    logic [EXP_W:0]        w_rnd_exp;
    logic                  w_rnd_ovf;
    logic                  w_of;
    logic                  w_nx;
    logic [EXP_W+FRAC_W:0] w_ovf_result;
    logic [EXP_W+FRAC_W:0] w_result;

    assign w_lsb = r_s1_frac[2];
    assign w_g   = r_s1_frac[1];
    assign w_s   = r_s1_frac[0];

    always_comb begin
        w_inc = 1'b0;
        case (r_s1_frm)
            3'b001:  w_inc = 1'b0;                      // RTZ
            3'b010:  w_inc = (w_g | w_s) & r_s1_sign;   // RDN
            3'b011:  w_inc = (w_g | w_s) & ~r_s1_sign;  // RUP
            3'b100:  w_inc = w_g;                       // RMM
            default: w_inc = w_g & (w_s | w_lsb);       // RNE and reserved codes
        endcase
    end

    // Hidden bit is always 1 for a normal value, so a carry out of the
    // fraction is exactly the all-ones mantissa rolling over.
    assign {w_rnd_carry, w_rnd_frac} = {1'b0, r_s1_frac[c_SIG_W-2:2]} + (FRAC_W+1)'(w_inc);
    assign w_rnd_exp = r_s1_exp + (EXP_W+1)'(w_rnd_carry);
    assign w_rnd_ovf = w_rnd_carry & (w_rnd_exp == {1'b0, c_EXP_ONES});

`ifdef FP_OVF_SAT_EN
    logic w_sat;
    assign w_sat = (r_s1_frm == 3'b001)
                 | ((r_s1_frm == 3'b010) & ~r_s1_sign)
                 | ((r_s1_frm == 3'b011) &  r_s1_sign);
    assign w_ovf_result = w_sat ? {r_s1_sign, c_EXP_MAX_FIN, {FRAC_W{1'b1}}}
                                : {r_s1_sign, c_EXP_ONES, FRAC_W'(0)};
`else
    assign w_ovf_result = {r_s1_sign, c_EXP_ONES, FRAC_W'(0)};
`endif

    always_comb begin
        w_of = r_s1_ovf | w_rnd_ovf;
        w_nx = (w_of | r_s1_unf | w_g | w_s) & ~r_s1_inv & ~r_s1_zero;
        if (r_s1_inv)
            w_result = {1'b0, c_EXP_ONES, 1'b1, (FRAC_W-1)'(0)};
        else if (w_of)
            w_result = w_ovf_result;
        else if (r_s1_unf | r_s1_zero)
            w_result = {r_s1_sign, (EXP_W+FRAC_W)'(0)};
        else
            w_result = {r_s1_sign, w_rnd_exp[EXP_W-1:0], w_rnd_frac};
    end

    logic [EXP_W+FRAC_W:0] r_fp_out;
    logic [4:0]            r_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_fp_out   <= '0;
            r_flags    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fp_out <= w_result;
                r_flags  <= {r_s1_inv, r_s1_dz, w_of, r_s1_unf, w_nx};
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.fp_out    = r_fp_out;
    assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_norm_round_pipe
// Purpose  : Self-checking bench for fp_norm_round_pipe (default 8/23 format).
//            Directed cases, backpressure, mid-flight reset and randomized
//            traffic checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_norm_round_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_norm_round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] sbq[$];   // {fp_out[31:0], flags[4:0]}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // Reference: significand kept as an integer value with two extra
    // low bits (G, S); normalisation and rounding done with plain arithmetic.
    function automatic logic [36:0] ref_model(input logic s, input logic [7:0] e,
            input logic [25:0] f, input logic c, input logic [2:0] rm,
            input logic inv, input logic dz, input logic ovi, input logic uni);
        int     ex;
        int     lz;
        longint sig;
        longint kept;
        bit     zero, ovf, unf, g, st, inc, of, uf, nx;
        logic [31:0] res;
        zero = (c == 1'b0) && (f == 26'd0);
        ovf  = 0;
        unf  = 0;
        if (c) begin
            sig = ((longint'(1) << 26) + longint'(f)) / 2;
            if (f[0]) sig = sig | 1;
            ex  = int'(e) + 1;
            ovf = (e == 8'hFE);
        end else begin
            lz = 0;
            while (lz < 26 && f[25 - lz] == 1'b0) lz++;
            sig = (longint'(f) << lz) % (longint'(1) << 26);
            ex  = int'(e) - lz;
            unf = !zero && (int'(e) <= lz);
        end
        g    = ((sig >> 1) & 1) != 0;
        st   = (sig & 1) != 0;
        kept = sig / 4;
        case (rm)
            3'd1:    inc = 0;
            3'd2:    inc = (g | st) & s;
            3'd3:    inc = (g | st) & !s;
            3'd4:    inc = g;
            default: inc = g & (st | ((kept & 1) != 0));
        endcase
        kept = kept + longint'(inc);
        if (kept == (longint'(1) << 24)) begin
            kept = longint'(1) << 23;
            ex   = ex + 1;
            if (ex == 255) ovf = 1;
        end
        of = ovi | ovf;
        uf = uni | unf;
        nx = (of | uf | g | st) & !inv & !zero;
        if (inv)
            res = 32'h7FC00000;
        else if (of) begin
            res = {s, 8'hFF, 23'd0};
`ifdef FP_OVF_SAT_EN
            if (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s))
                res = {s, 8'hFE, 23'h7FFFFF};
`endif
        end else if (uf || zero)
            res = {s, 31'd0};
        else
            res = {s, 8'(ex), 23'(kept)};
        return {res, inv, dz, of, uf, nx};
    endfunction

    task automatic set_beat(input logic v, input logic s, input logic [7:0] e,
            input logic [25:0] f, input logic c, input logic [2:0] rm,
            input logic inv, input logic dz, input logic ov, input logic un);
        bus.in_valid  = v;
        bus.sign_in   = s;
        bus.exp_in    = e;
        bus.frac_in   = f;
        bus.carry_out = c;
        bus.frm       = rm;
        bus.inv_in    = inv;
        bus.dz_in     = dz;
        bus.ovf_in    = ov;
        bus.unf_in    = un;
    endtask

    task automatic rand_beat(input logic v);
        logic [25:0] f;
        logic [7:0]  e;
        logic        c;
        f = 26'($urandom) >> $urandom_range(0, 26);
        if ($urandom_range(0, 7) == 0) f = 26'h3FFFFFF ^ 26'($urandom_range(0, 3));
        e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 254));
        c = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) begin
            e = 8'hFE;
            c = 1'b1;
        end
        set_beat(v, 1'($urandom), e, f, c, 3'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0));
    endtask

    // Called at a negedge with inputs set; samples just after, then advances
    // to the next negedge.
    task automatic step(output bit acc);
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check("sb_fp_out", 64'(bus.fp_out), 64'(sbq[0][36:5]));
                check("sb_flags",  64'(bus.flags),  64'(sbq[0][4:0]));
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
        if (acc)
            sbq.push_back(ref_model(bus.sign_in, bus.exp_in, bus.frac_in, bus.carry_out,
                                    bus.frm, bus.inv_in, bus.dz_in, bus.ovf_in, bus.unf_in));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int cyc;
        bit acc;
        cyc = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sbq.size() != 0 && cyc < 200) begin
            step(acc);
            cyc++;
        end
        check(tag, 64'(sbq.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e,
            input logic [25:0] f, input logic c, input logic [2:0] rm,
            input logic inv, input logic dz, input logic [31:0] x_fp, input logic [4:0] x_fl);
        bit acc;
        bus.out_ready = 1'b1;
        set_beat(1'b1, s, e, f, c, rm, inv, dz, 1'b0, 1'b0);
        step(acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
        step(acc);
        check({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_fp_out"}, 64'(bus.fp_out), 64'(x_fp));
        check({tag, "_flags"}, 64'(bus.flags), 64'(x_fl));
        step(acc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        int seen;
        logic [31:0] x_sat;

        set_beat(1'b0, 1'b0, 8'd0, 26'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_fp_out",    64'(bus.fp_out),    64'd0);
        check("reset_flags",     64'(bus.flags),     64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);

        directed("normal",   1'b0, 8'h80, 26'h2000000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40000000, 5'b00000);
        directed("rne_carry",1'b0, 8'h7F, 26'h3FFFFFE, 1'b0, 3'd0, 1'b0, 1'b0, 32'h40000000, 5'b00001);
        directed("rtz_trunc",1'b0, 8'h7F, 26'h3FFFFFE, 1'b0, 3'd1, 1'b0, 1'b0, 32'h3FFFFFFF, 5'b00001);
        directed("ovf_rne",  1'b0, 8'hFE, 26'h0000000, 1'b1, 3'd0, 1'b0, 1'b0, 32'h7F800000, 5'b00101);
`ifdef FP_OVF_SAT_EN
        x_sat = 32'h7F7FFFFF;
`else
        x_sat = 32'h7F800000;
`endif
        directed("ovf_rtz",  1'b0, 8'hFE, 26'h0000000, 1'b1, 3'd1, 1'b0, 1'b0, x_sat, 5'b00101);
        directed("underflow",1'b0, 8'h03, 26'h0100000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h00000000, 5'b00011);
        directed("neg_zero", 1'b1, 8'h40, 26'h0000000, 1'b0, 3'd0, 1'b0, 1'b0, 32'h80000000, 5'b00000);
        directed("invalid",  1'b1, 8'h80, 26'h2345678, 1'b0, 3'd0, 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
        directed("div_zero", 1'b0, 8'h80, 26'h2000000, 1'b0, 3'd0, 1'b0, 1'b1, 32'h40000000, 5'b01000);
        drain("directed_drain");

        // backpressure: three back-to-back beats into a stalled output
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            rand_beat(1'b1);
            #1;
            if (k == 2) check("bp_in_ready_third", 64'(bus.in_ready), 64'd0);
            step(acc);
            n_acc += int'(acc);
        end
        check("bp_accepted", 64'(n_acc), 64'd2);
        drain("bp_drain");

        // reset with two beats in flight
        bus.out_ready = 1'b0;
        rand_beat(1'b1);
        step(acc);
        rand_beat(1'b1);
        step(acc);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step(acc);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_fp_out",    64'(bus.fp_out),    64'd0);
        check("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
        sbq.delete();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            if (bus.out_valid) seen++;
            step(acc);
        end
        check("rst_no_stale", 64'(seen), 64'd0);

        // randomized traffic with random backpressure
        for (int cyc = 0; cyc < 600; cyc++) begin
            rand_beat($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_norm_round_pipe.md
# fp_norm_round_pipe

Parametrised, two-stage pipelined normalise/round/exception stage that closes the FP adder datapath. It takes the raw sum from the align/add stage and produces an IEEE-754 result plus RISC-V fflags. It replaces the combinational final add step with a registered valid/ready stage, generic in exponent and fraction width. It adds behaviour the earlier stage lacks: all five rounding modes with mantissa-carry renormalisation, exact-zero handling, canonical NaN, and backpressure.

## Interface
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; internal significand is FRAC_W+3 bits: {hidden, fraction, G, S}.
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
- sign_in  in  1  result sign.
- exp_in  in  EXP_W  biased exponent before normalisation.
- frac_in  in  FRAC_W+3  unnormalised significand.
- carry_out  in  1  adder carry above frac_in MSB.
- frm  in  3  rounding mode.
- inv_in, dz_in, ovf_in, unf_in  in  1 each  exception flags from earlier stages.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- fp_out  out  1+EXP_W+FRAC_W  {sign, exponent, fraction}.
- flags  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- S1 (normalise), registered:
  - If carry_out=1, shift right 1: hidden=carry, S = OR of the dropped bits; exp = exp_in+1.
  - Else, lzc = leading-zero count of frac_in; shift left by lzc; exp = exp_in-lzc.
  - zero: carry_out=0 and frac_in=0.
  - ovf: carry path and exp_in = 2^EXP_W-2.
  - unf: non-carry, not zero, exp_in ≤ lzc (result exponent ≤ 0).
  - All arithmetic is EXP_W+1 bits wide, so no wrap.
- S2 (round/select), registered:
  - inc rule by frm:
    - RNE (000): G&(S|LSB).
    - RTZ (001): 0.
    - RDN (010): (G|S)&sign.
    - RUP (011): (G|S)&~sign.
    - RMM (100): G.
    - 101–111: treated as RNE.
  - Mantissa all-ones plus inc carries into hidden: fraction becomes 0, exp+1. If exp then equals all-ones, raise ovf.
- Result priority:
  - inv_in: canonical qNaN (sign 0, exp all-ones, fraction MSB 1).
  - ovf_in|ovf: ±inf.
  - unf_in|unf: ±0.
  - zero: ±0 with sign_in, exp 0.
  - otherwise the rounded value.
- Flags:
  - NV = inv_in.
  - DZ = dz_in.
  - OF = ovf_in|ovf.
  - UF = unf_in|unf.
  - NX = OF|UF|G|S. NX is forced 0 when inv_in or zero.

## Timing
- Latency is exactly 2 cycles from an input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Each stage holds a valid bit. A stage loads when it is empty or the next stage advances in the same cycle.
- in_ready = ~s1_valid | ~s2_valid | out_ready. This is combinational from out_ready; no path exists from in_valid.
- While out_valid=1 and out_ready=0, fp_out and flags hold stable.
- Input and output transfers in the same cycle are lossless. Beat order is preserved.
- Reset values:
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, fp_out=0, flags=0, both stage valids 0.
- RST mid-operation discards in-flight beats with no output pulse.

## Configuration
- FP_OVF_SAT_EN defined: overflow result follows IEEE rounding direction.
  - RTZ gives ±max-finite (exp all-ones-1, fraction all-ones).
  - RDN gives +max-finite for positive results.
  - RUP gives −max-finite for negative results.
  - Other cases give ±inf. Flags are unchanged.
- FP_OVF_SAT_EN undefined: overflow always gives ±inf.

## Test plan
All scenarios use default parameters.
- Normal: exp_in=0x80, frac_in=0x2000000, carry=0, sign=0, frm=000 -> fp_out=0x40000000, flags=00000, out_valid exactly 2 cycles after accept.
- Round carry: exp_in=0x7F, frac_in=0x3FFFFFE, frm=000 -> 0x40000000, flags=00001. Same input with frm=001 -> 0x3FFFFFFF, flags=00001.
- Overflow: exp_in=0xFE, carry=1, frac_in=0, frm=000 -> 0x7F800000, flags=00101. With FP_OVF_SAT_EN and frm=001 -> 0x7F7FFFFF.
- Underflow/zero: exp_in=0x03, frac_in=0x0100000 -> 0x00000000, flags=00011. frac_in=0, sign=1 -> 0x80000000, flags=00000.
- Exceptions: inv_in=1 with any data -> 0x7FC00000, flags=10000. dz_in=1 with a normal input -> DZ set, result unaffected.
- Backpressure/reset:
  - Hold out_ready=0 and send 3 back-to-back beats -> only 2 accepted, in_ready=0 on the third; release -> results emerge in order, none lost.
  - Assert RST with 2 beats in flight -> out_valid=0 the next cycle and no stale beat emitted.
